// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter: round-robin grant locked for the whole cyc,
// with a watchdog that aborts a stalled strobe with a one-cycle error to its owner.
module wb_arbiter2 #(
  parameter int TIMEOUT = 600,
  parameter int CNT_W   = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_m_cyc,
  input  logic [1:0]  i_m_stb,
  input  logic [1:0]  i_m_we,
  input  logic [7:0]  i_m_sel,
  input  logic [63:0] i_m_adr,
  input  logic [63:0] i_m_dat,
  output logic [31:0] o_m_dat,
  output logic [1:0]  o_m_ack,
  output logic [1:0]  o_m_err,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt, last_owner;
  logic [CNT_W-1:0] wdog, wdog_nxt;
  logic             own_cyc, own_stb, busy;

  assign own_cyc = i_m_cyc[owner];
  assign own_stb = i_m_stb[owner];
  // Slave-side signals are cut off combinationally while reset is held.
  assign busy    = (state == BUSY) && !i_rst;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    wdog_nxt  = '0;
    case (state)
      IDLE: begin
        if (i_m_cyc != 2'b00) begin
          state_nxt = BUSY;
          owner_nxt = (i_m_cyc == 2'b11) ? ~last_owner : i_m_cyc[1];
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
        end else if (own_stb && !i_s_ack) begin
          if (wdog == CNT_W'(TIMEOUT - 1)) state_nxt = ABORT;
          else                             wdog_nxt  = wdog + 1'b1;
        end
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wdog       <= '0;
      o_grant    <= 2'b00;
      o_m_err    <= 2'b00;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      wdog    <= wdog_nxt;
      o_grant <= (state_nxt != IDLE) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
      o_m_err <= (state_nxt == ABORT) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
      if (state != IDLE && state_nxt == IDLE) last_owner <= owner;
    end
  end

  assign o_s_cyc = busy && own_cyc;
  assign o_s_stb = busy && own_stb;
  assign o_s_we  = i_m_we[owner];
  assign o_s_sel = owner ? i_m_sel[7:4]   : i_m_sel[3:0];
  assign o_s_adr = owner ? i_m_adr[63:32] : i_m_adr[31:0];
  assign o_s_dat = owner ? i_m_dat[63:32] : i_m_dat[31:0];
  assign o_m_dat = i_s_dat;
  assign o_m_ack = (busy && i_s_ack) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed plan steps plus a randomized phase, all checked each cycle
// against a transaction-level ownership model.
module tb_wb_arbiter2;
  localparam int TO = 8;

  logic        clk;
  logic        i_rst;
  logic [1:0]  i_m_cyc, i_m_stb, i_m_we;
  logic [7:0]  i_m_sel;
  logic [63:0] i_m_adr, i_m_dat;
  logic [31:0] o_m_dat;
  logic [1:0]  o_m_ack, o_m_err, o_grant;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [3:0]  o_s_sel;
  logic [31:0] o_s_adr, o_s_dat, i_s_dat;
  logic        i_s_ack;

  wb_arbiter2 #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_sel(i_m_sel), .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .o_m_dat(o_m_dat),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .o_s_we(o_s_we), .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
    .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .o_grant(o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last,
  // how long the owner's strobe has waited, and whether an error cycle is due.
  int own = -1;
  int last = 1;
  int wait_cnt = 0;
  bit aborting = 0;

  logic [1:0] smp_ack;
  logic       smp_scyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                      input logic ack);
    logic [1:0] e_grant, e_ack, e_err;
    logic       e_scyc;
    @(negedge clk);
    i_rst   = rst;
    i_m_cyc = cyc;
    i_m_stb = stb;
    i_s_ack = ack;
    i_s_dat = $urandom;
    i_m_we  = 2'($urandom);
    i_m_sel = 8'($urandom);
    i_m_dat = {$urandom, $urandom};
    #1;
    e_grant = (own < 0) ? 2'b00 : 2'(1 << own);
    e_err   = (aborting && own >= 0) ? 2'(1 << own) : 2'b00;
    e_scyc  = !rst && own >= 0 && !aborting && cyc[own];
    e_ack   = (!rst && own >= 0 && !aborting && ack) ? 2'(1 << own) : 2'b00;
    chk("grant", 32'(o_grant), 32'(e_grant));
    chk("m_err", 32'(o_m_err), 32'(e_err));
    chk("s_cyc", 32'(o_s_cyc), 32'(e_scyc));
    chk("m_ack", 32'(o_m_ack), 32'(e_ack));
    chk("m_dat", o_m_dat, i_s_dat);
    if (e_scyc) begin
      chk("s_stb", 32'(o_s_stb), 32'(stb[own]));
      chk("s_adr", o_s_adr, i_m_adr[own*32 +: 32]);
      chk("s_dat", o_s_dat, i_m_dat[own*32 +: 32]);
      chk("s_sel", 32'(o_s_sel), 32'(i_m_sel[own*4 +: 4]));
      chk("s_we",  32'(o_s_we),  32'(i_m_we[own]));
    end
    smp_ack  = o_m_ack;
    smp_scyc = o_s_cyc;
    @(posedge clk);
    if (rst) begin
      own = -1; last = 1; wait_cnt = 0; aborting = 0;
    end else if (aborting) begin
      last = own; own = -1; aborting = 0;
    end else if (own < 0) begin
      if (cyc != 2'b00) own = (cyc == 2'b11) ? 1 - last : (cyc[1] ? 1 : 0);
      wait_cnt = 0;
    end else if (!cyc[own]) begin
      last = own; own = -1; wait_cnt = 0;
    end else if (stb[own] && !ack) begin
      if (wait_cnt == TO - 1) begin aborting = 1; wait_cnt = 0; end
      else wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    #1;
  endtask

  initial begin
    int k;
    int m0_acks;
    logic [1:0] rc;
    i_rst = 1'b1; i_m_cyc = '0; i_m_stb = '0; i_m_we = '0; i_m_sel = '0;
    i_m_adr = '0; i_m_dat = '0; i_s_dat = '0; i_s_ack = 1'b0;

    // Reset state
    step(1, 2'b00, 2'b00, 0);
    step(1, 2'b00, 2'b00, 0);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_err",   32'(o_m_err), 32'h0);

    // Single master write, spurious ack in IDLE ignored
    step(0, 2'b00, 2'b00, 1);
    i_m_adr = {32'h0, 32'h500};
    step(0, 2'b01, 2'b01, 0);
    chk("single_grant", 32'(o_grant), 32'h1);
    step(0, 2'b01, 2'b01, 0);
    chk("single_adr", o_s_adr, 32'h500);
    step(0, 2'b01, 2'b01, 0);
    step(0, 2'b01, 2'b01, 1);
    chk("single_ack", 32'(smp_ack), 32'h1);
    step(0, 2'b00, 2'b00, 0);
    chk("single_err", 32'(o_m_err), 32'h0);

    // Simultaneous request after reset: m0, then m1, then m0 again
    step(1, 2'b00, 2'b00, 0);
    step(0, 2'b11, 2'b11, 0);
    chk("tie0_grant", 32'(o_grant), 32'h1);
    step(0, 2'b11, 2'b11, 1);
    step(0, 2'b10, 2'b10, 0);
    chk("tie_idle", 32'(o_grant), 32'h0);
    step(0, 2'b10, 2'b10, 0);
    chk("tie1_grant", 32'(o_grant), 32'h2);
    step(0, 2'b10, 2'b10, 1);
    step(0, 2'b00, 2'b00, 0);
    step(0, 2'b11, 2'b11, 0);
    chk("tie2_grant", 32'(o_grant), 32'h1);
    step(0, 2'b00, 2'b00, 0);

    // Lock: m1 does three reads while m0 waits
    m0_acks = 0;
    i_m_adr = {32'h504, 32'h600};
    step(0, 2'b10, 2'b10, 0);
    step(0, 2'b11, 2'b11, 1); m0_acks += int'(smp_ack[0]);
    i_m_adr = {32'h508, 32'h600};
    step(0, 2'b11, 2'b11, 0); m0_acks += int'(smp_ack[0]);
    chk("lock_adr", o_s_adr, 32'h508);
    step(0, 2'b11, 2'b11, 1); m0_acks += int'(smp_ack[0]);
    i_m_adr = {32'h50C, 32'h600};
    step(0, 2'b11, 2'b11, 1); m0_acks += int'(smp_ack[0]);
    chk("lock_m0_acks", 32'(m0_acks), 32'h0);
    step(0, 2'b01, 2'b01, 0);
    chk("lock_idle", 32'(o_grant), 32'h0);
    step(0, 2'b01, 2'b01, 0);
    chk("lock_handover", 32'(o_grant), 32'h1);
    step(0, 2'b00, 2'b00, 0);

    // Timeout: m0 never acked, m1 pending
    step(0, 2'b01, 2'b01, 0);
    k = 1;
    while (k < 20 && !o_m_err[0]) begin
      step(0, 2'b11, 2'b11, 0);
      k++;
    end
    chk("timeout_cycle", 32'(k), 32'd9);
    chk("timeout_scyc", 32'(o_s_cyc), 32'h0);
    step(0, 2'b10, 2'b10, 0);
    step(0, 2'b10, 2'b10, 0);
    chk("timeout_m1_grant", 32'(o_grant), 32'h2);
    step(0, 2'b00, 2'b00, 0);

    // Ack exactly at the watchdog boundary
    step(0, 2'b01, 2'b01, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 2'b01, 2'b01, 0);
    step(0, 2'b01, 2'b01, 1);
    chk("bound_ack", 32'(smp_ack), 32'h1);
    chk("bound_err", 32'(o_m_err), 32'h0);
    chk("bound_grant", 32'(o_grant), 32'h1);
    step(0, 2'b00, 2'b00, 0);

    // Reset mid-transfer while m1 owns
    step(0, 2'b10, 2'b10, 0);
    step(0, 2'b10, 2'b10, 0);
    step(1, 2'b10, 2'b10, 1);
    chk("rst_mid_scyc", 32'(smp_scyc), 32'h0);
    chk("rst_mid_grant", 32'(o_grant), 32'h0);
    step(0, 2'b00, 2'b00, 0);
    step(0, 2'b11, 2'b11, 0);
    chk("rst_mid_tie", 32'(o_grant), 32'h1);
    step(0, 2'b00, 2'b00, 0);

    // Randomized traffic against the model
    rc = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) rc[0] = ~rc[0];
      if ($urandom_range(3) == 0) rc[1] = ~rc[1];
      i_m_adr = {$urandom, $urandom};
      step(($urandom_range(99) == 0), rc, 2'($urandom) | 2'($urandom),
           ($urandom_range(3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone (classic, single-beat) arbiter.
- Shares the wb_slave_test memory between the MIPS core (master 0) and a second master (master 1): boot loader, DMA or bench driver.
- Round-robin grant, locked for the whole cyc, with a watchdog that terminates hung cycles with an error.

Parameters:
TIMEOUT, 600, cycles stb may stay asserted without slave ack before the arbiter aborts
CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_m_cyc  input  2  per-master cyc, bit n = master n
i_m_stb  input  2  per-master stb
i_m_we  input  2  per-master we
i_m_sel  input  8  per-master sel, [4n+3:4n]
i_m_adr  input  64  per-master adr, [32n+31:32n]
i_m_dat  input  64  per-master write data, [32n+31:32n]
o_m_dat  output  32  read data, broadcast to both masters
o_m_ack  output  2  per-master ack
o_m_err  output  2  per-master error (watchdog abort)
o_s_cyc  output  1  slave cyc
o_s_stb  output  1  slave stb
o_s_we  output  1  slave we
o_s_sel  output  4  slave sel
o_s_adr  output  32  slave adr
o_s_dat  output  32  slave write data
i_s_dat  input  32  slave read data
i_s_ack  input  1  slave ack
o_grant  output  2  one-hot current owner, 0 when idle

Behaviour:
- Reset: synchronous, active-high, on i_clk. Clock and reset are i_clk / i_rst.
- Reset values: state=IDLE, o_grant=0, last_owner=1 (so master 0 wins the first tie), wdog=0, o_m_err=0.
- During reset and IDLE, o_s_cyc/o_s_stb/o_m_ack = 0.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - No cyc -> stay.
  - One cyc -> grant that master.
  - Both cyc -> grant the master != last_owner.
  - Grant is registered: BUSY and o_grant valid the cycle after the request is seen (1-cycle arbitration latency).
- BUSY, owner n:
  - o_s_cyc/stb/we/sel/adr/dat = master n signals, combinational pass-through.
  - o_m_ack[n] = i_s_ack; o_m_ack of the other master = 0.
  - o_m_dat = i_s_dat always.
  - Non-owner is stalled and never sees ack.
- Lock: owner keeps the grant for multiple stb beats while its cyc stays high.
- Release: when i_m_cyc[n]=0 in BUSY, go to IDLE, last_owner=n, o_grant=0. At least one idle cycle separates owners.
- Watchdog:
  - wdog increments each BUSY cycle with owner stb=1 and i_s_ack=0.
  - Clears on ack, on stb=0, or on leaving BUSY.
  - When wdog reaches TIMEOUT-1 with no ack: next state ABORT.
- ABORT (exactly 1 cycle):
  - o_s_cyc=o_s_stb=0; o_m_err[n]=1; o_m_ack[n]=0.
  - Then IDLE with last_owner=n.
  - The master must drop cyc; if it holds cyc it re-arbitrates normally.
- Ack and timeout in the same cycle: ack wins, no abort.
- Grant-on-ack and a new request in the same cycle: the new request waits for IDLE arbitration.
- Ack while not in BUSY (spurious): ignored, no o_m_ack asserted.
- Reset asserted mid-cycle: next edge forces IDLE. Slave signals drop that cycle; an in-flight ack is lost.
- Outputs o_m_ack, o_m_dat and o_s_* are combinational from the grant register; o_grant and o_m_err are registered.

Test Plan:
- Single master: after reset, m0 write adr=0x500 dat=0x15, slave acks after 2 cycles -> o_grant=01 one cycle after cyc; o_s_adr=0x500; o_m_ack=01 for 1 cycle; o_m_err=0.
- Simultaneous request: m0 and m1 assert cyc on the same edge after reset -> m0 granted first. After m0 drops cyc, one IDLE cycle, then o_grant=10. Next simultaneous request -> m0 again (alternation).
- Lock: m1 does 3 back-to-back reads (0x504, 0x508, 0x50C) holding cyc while m0 requests -> m0 sees o_m_ack[0]=0 until m1 drops cyc, then o_grant=01.
- Timeout: TIMEOUT=8, m0 stb high, slave never acks -> o_m_err[0]=1 exactly on the 9th cycle after grant, with o_s_cyc=0 that cycle. A pending m1 is then granted 2 cycles later.
- Ack at boundary: slave acks on cycle TIMEOUT-1 -> o_m_ack[0]=1, o_m_err=0, state stays BUSY.
- Reset mid-transfer: i_rst=1 while m1 owns with stb high -> next cycle o_grant=0, o_s_cyc=0. After release, a simultaneous request grants m0.
